// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - phase encodings and default 640x480@60 timing for the VGA raster
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phaseT;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic phaseT nextPhase(input phaseT cur);
    case (cur)
      ACTIVE:  return FRONT;
      FRONT:   return SYNC;
      SYNC:    return BACK;
      default: return ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - wrapping up-counter 0..LIM-1 that advances while iEn is high
module counter #(
  parameter int LIM = 2,
  parameter int W   = (LIM > 1) ? $clog2(LIM) : 1
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iEn,
  output logic [W-1:0] oCount
);

  localparam logic [W-1:0] TOP = W'(LIM - 1);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oCount <= '0;
    end else if (iEn) begin
      oCount <= (oCount == TOP) ? '0 : oCount + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster sequencer: pixel divider, h/v counters, phase FSMs, output register
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW       = $clog2(H_TOTAL),
  localparam int  YW       = $clog2(V_TOTAL)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iEn,
  output logic          oHSync,
  output logic          oVSync,
  output logic          oVideoOn,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic          oPixTick,
  output logic          oFrameStart
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Last count of each phase; the FSM leaves a phase as the counter steps off it.
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] H_FP_END   = XW'(H_ACTIVE + H_FP - 1);
  localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] V_FP_END   = YW'(V_ACTIVE + V_FP - 1);
  localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

  logic [DW-1:0] divCount;
  logic [XW-1:0] hCount;
  logic [YW-1:0] vCount;
  logic          tick;
  logic          hLast;
  logic          vAdv;

  phaseT         hState, hStateNxt;
  phaseT         vState, vStateNxt;
  logic [XW-1:0] hEnd;
  logic [YW-1:0] vEnd;

  assign tick  = iEn & (divCount == DIV_LAST);
  assign hLast = (hCount == H_LAST);
  assign vAdv  = tick & hLast;

  counter #(.LIM(CLK_DIV), .W(DW)) uDiv (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (iEn),
    .oCount (divCount)
  );

  counter #(.LIM(H_TOTAL), .W(XW)) uHCnt (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (tick),
    .oCount (hCount)
  );

  counter #(.LIM(V_TOTAL), .W(YW)) uVCnt (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEn    (vAdv),
    .oCount (vCount)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      hState <= ACTIVE;
      vState <= ACTIVE;
    end else begin
      hState <= hStateNxt;
      vState <= vStateNxt;
    end
  end

  always_comb begin
    hEnd      = H_LAST;
    vEnd      = V_LAST;
    hStateNxt = hState;
    vStateNxt = vState;
    case (hState)
      ACTIVE:  hEnd = H_ACT_END;
      FRONT:   hEnd = H_FP_END;
      SYNC:    hEnd = H_SYNC_END;
      default: hEnd = H_LAST;
    endcase
    case (vState)
      ACTIVE:  vEnd = V_ACT_END;
      FRONT:   vEnd = V_FP_END;
      SYNC:    vEnd = V_SYNC_END;
      default: vEnd = V_LAST;
    endcase
    if (tick && (hCount == hEnd)) hStateNxt = nextPhase(hState);
    if (vAdv && (vCount == vEnd)) vStateNxt = nextPhase(vState);
  end

  // Every output is taken from the same pre-edge state, so they stay mutually aligned.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oX          <= '0;
      oY          <= '0;
      oVideoOn    <= 1'b0;
      oHSync      <= ~SYNC_POL;
      oVSync      <= ~SYNC_POL;
      oPixTick    <= 1'b0;
      oFrameStart <= 1'b0;
    end else if (iEn) begin
      oX          <= hCount;
      oY          <= vCount;
      oVideoOn    <= (hState == ACTIVE) && (vState == ACTIVE);
      oHSync      <= (hState == SYNC) ? SYNC_POL : ~SYNC_POL;
      oVSync      <= (vState == SYNC) ? SYNC_POL : ~SYNC_POL;
      oPixTick    <= tick;
      oFrameStart <= tick && (hCount == '0) && (vCount == '0);
    end else begin
      oPixTick    <= 1'b0;
      oFrameStart <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed self-checking bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic iEn  = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 iClk = ~iClk;

  logic       aHSync, aVSync, aVideoOn, aPixTick, aFrameStart;
  logic [9:0] aX, aY;
  logic       bHSync, bVSync, bVideoOn, bPixTick, bFrameStart;
  logic [2:0] bX, bY;
  logic       cHSync, cVSync, cVideoOn, cPixTick, cFrameStart;
  logic [3:0] cX;
  logic [2:0] cY;

  vga_timing_ctrl dutA (
    .iClk(iClk), .iRst(iRst), .iEn(iEn),
    .oHSync(aHSync), .oVSync(aVSync), .oVideoOn(aVideoOn),
    .oX(aX), .oY(aY), .oPixTick(aPixTick), .oFrameStart(aFrameStart)
  );

  vga_timing_ctrl #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dutB (
    .iClk(iClk), .iRst(iRst), .iEn(iEn),
    .oHSync(bHSync), .oVSync(bVSync), .oVideoOn(bVideoOn),
    .oX(bX), .oY(bY), .oPixTick(bPixTick), .oFrameStart(bFrameStart)
  );

  vga_timing_ctrl #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dutC (
    .iClk(iClk), .iRst(iRst), .iEn(iEn),
    .oHSync(cHSync), .oVSync(cVSync), .oVideoOn(cVideoOn),
    .oX(cX), .oY(cY), .oPixTick(cPixTick), .oFrameStart(cFrameStart)
  );

  // Leaves the bench on a falling edge with iRst low; the next rising edge is edge 1.
  task automatic doReset();
    iRst = 1'b1;
    iEn  = 1'b1;
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic test_reset();
    logic expPix, expFsA, expFsB, expFsC, expPixC;
    iRst = 1'b1;
    iEn  = 1'b0;
    repeat (3) @(negedge iClk);
    checks++;
    if ({aX, aY, aVideoOn, aPixTick, aFrameStart, aHSync, aVSync} !== {20'd0, 3'b000, 2'b11}) begin
      failures++;
      $display("FAIL reset_a: x=%0d y=%0d vid=%b pix=%b fs=%b hs=%b vs=%b, want 0 0 0 0 0 1 1",
               aX, aY, aVideoOn, aPixTick, aFrameStart, aHSync, aVSync);
    end
    checks++;
    if ({cHSync, cVSync, cVideoOn} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pol1_sync: hs=%b vs=%b vid=%b, want 0 0 0", cHSync, cVSync, cVideoOn);
    end
    checks++;
    if ({bX, bY, bHSync, bVSync, bPixTick} !== {6'd0, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL reset_b: x=%0d y=%0d hs=%b vs=%b pix=%b, want 0 0 1 1 0", bX, bY, bHSync, bVSync, bPixTick);
    end
    iEn  = 1'b1;
    iRst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge iClk);
      if (k == 1) begin
        checks++;
        if ({aVideoOn, aX, aY} !== {1'b1, 20'd0}) begin
          failures++;
          $display("FAIL first_edge: vid=%b x=%0d y=%0d, want 1 0 0", aVideoOn, aX, aY);
        end
      end
      expPix  = (k % 4) == 0;
      expFsA  = (k == 4);
      expFsB  = (k == 1);
      expPixC = (k % 2) == 0;
      expFsC  = (k == 2);
      checks++;
      if ({aPixTick, aFrameStart, bPixTick, bFrameStart, cPixTick, cFrameStart} !==
          {expPix, expFsA, 1'b1, expFsB, expPixC, expFsC}) begin
        failures++;
        $display("FAIL first_pulses edge %0d: a=%b%b b=%b%b c=%b%b, want a=%b%b b=1%b c=%b%b", k,
                 aPixTick, aFrameStart, bPixTick, bFrameStart, cPixTick, cFrameStart,
                 expPix, expFsA, expFsB, expPixC, expFsC);
      end
    end
  endtask

  task automatic test_line_timing();
    int vidHigh, firstLow, hsLow, firstHs, pixCnt, xBad;
    vidHigh = 0; firstLow = 0; hsLow = 0; firstHs = 0; pixCnt = 0; xBad = 0;
    doReset();
    for (int k = 1; k <= 3200; k++) begin
      @(negedge iClk);
      if (aVideoOn) vidHigh++;
      else if (firstLow == 0) firstLow = k;
      if (!aHSync) begin
        hsLow++;
        if (firstHs == 0) firstHs = k;
      end
      if (aPixTick) pixCnt++;
      if (xBad == 0 && (int'(aX) != (k - 1) / 4 || aY !== 10'd0 || aVSync !== 1'b1)) xBad = k;
    end
    checks++;
    if (vidHigh != 2560) begin failures++; $display("FAIL line_video_high: got %0d clks, want 2560", vidHigh); end
    checks++;
    if (firstLow != 2561) begin failures++; $display("FAIL line_video_fall: got edge %0d, want 2561", firstLow); end
    checks++;
    if (hsLow != 384) begin failures++; $display("FAIL line_hsync_len: got %0d clks, want 384", hsLow); end
    checks++;
    if (firstHs != 2625) begin failures++; $display("FAIL line_hsync_start: got edge %0d, want 2625", firstHs); end
    checks++;
    if (pixCnt != 800) begin failures++; $display("FAIL line_pixticks: got %0d, want 800", pixCnt); end
    checks++;
    if (xBad != 0) begin failures++; $display("FAIL line_x_seq: first bad edge %0d, want none", xBad); end
    @(negedge iClk);
    checks++;
    if ({aX, aY, aVideoOn} !== {10'd0, 10'd1, 1'b1}) begin
      failures++;
      $display("FAIL line_wrap: x=%0d y=%0d vid=%b, want 0 1 1", aX, aY, aVideoOn);
    end
  endtask

  task automatic test_frame_timing();
    int ex, ey, firstBad, vsHigh, firstVs, hsHigh, firstHs, fs1, fs2;
    logic expVid, expHs, expVs, expFs, expPix;
    firstBad = 0; vsHigh = 0; firstVs = 0; hsHigh = 0; firstHs = 0; fs1 = 0; fs2 = 0;
    doReset();
    for (int k = 1; k <= 448; k++) begin
      @(negedge iClk);
      ex     = ((k - 1) / 2) % 14;
      ey     = ((k - 1) / 28) % 8;
      expVid = (ex < 8) && (ey < 4);
      expHs  = (ex >= 10) && (ex <= 12);
      expVs  = (ey >= 5) && (ey <= 6);
      expFs  = ((k - 1) % 224) == 1;
      expPix = (k % 2) == 0;
      if (firstBad == 0 && (int'(cX) != ex || int'(cY) != ey || cVideoOn !== expVid ||
          cHSync !== expHs || cVSync !== expVs || cFrameStart !== expFs || cPixTick !== expPix))
        firstBad = k;
      if (k <= 224 && cVSync === 1'b1) begin
        vsHigh++;
        if (firstVs == 0) firstVs = k;
      end
      if (k <= 28 && cHSync === 1'b1) begin
        hsHigh++;
        if (firstHs == 0) firstHs = k;
      end
      if (cFrameStart === 1'b1) begin
        if (fs1 == 0) fs1 = k;
        else if (fs2 == 0) fs2 = k;
      end
    end
    checks++;
    if (firstBad != 0) begin failures++; $display("FAIL frame_seq: first bad edge %0d, want none", firstBad); end
    checks++;
    if (vsHigh != 56) begin failures++; $display("FAIL frame_vsync_len: got %0d clks, want 56", vsHigh); end
    checks++;
    if (firstVs != 141) begin failures++; $display("FAIL frame_vsync_start: got edge %0d, want 141", firstVs); end
    checks++;
    if (hsHigh != 6 || firstHs != 21) begin
      failures++;
      $display("FAIL frame_hsync: got len %0d start %0d, want 6 21", hsHigh, firstHs);
    end
    checks++;
    if (fs1 != 2 || fs2 - fs1 != 224) begin
      failures++;
      $display("FAIL frame_period: got first %0d period %0d, want 2 224", fs1, fs2 - fs1);
    end
  endtask

  task automatic test_min_params();
    int ex, ey, firstBad, fsCount;
    logic expVid, expHs, expVs, expFs;
    firstBad = 0; fsCount = 0;
    doReset();
    for (int k = 1; k <= 96; k++) begin
      @(negedge iClk);
      ex     = (k - 1) % 8;
      ey     = ((k - 1) / 8) % 6;
      expVid = (ex < 4) && (ey < 3);
      expHs  = !((ex == 5) || (ex == 6));
      expVs  = (ey != 4);
      expFs  = ((k - 1) % 48) == 0;
      if (bFrameStart === 1'b1) fsCount++;
      if (firstBad == 0 && (int'(bX) != ex || int'(bY) != ey || bVideoOn !== expVid ||
          bHSync !== expHs || bVSync !== expVs || bFrameStart !== expFs || bPixTick !== 1'b1))
        firstBad = k;
      if (k == 9 || k == 49) begin
        checks++;
        if ({bX, bY} !== {3'd0, (k == 9) ? 3'd1 : 3'd0}) begin
          failures++;
          $display("FAIL min_wrap edge %0d: x=%0d y=%0d, want 0 %0d", k, bX, bY, (k == 9) ? 1 : 0);
        end
      end
    end
    checks++;
    if (firstBad != 0) begin failures++; $display("FAIL min_seq: first bad edge %0d, want none", firstBad); end
    checks++;
    if (fsCount != 2) begin failures++; $display("FAIL min_framestarts: got %0d in 96 clks, want 2", fsCount); end
  endtask

  task automatic test_enable_pause();
    int holdBad, expX;
    logic expPix;
    holdBad = 0;
    doReset();
    repeat (401) @(negedge iClk);
    checks++;
    if ({aX, aPixTick} !== {10'd100, 1'b0}) begin
      failures++;
      $display("FAIL pause_entry: x=%0d pix=%b, want 100 0", aX, aPixTick);
    end
    iEn = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iClk);
      if (holdBad == 0 && {aX, aY, aVideoOn, aHSync, aVSync, aPixTick, aFrameStart} !==
          {10'd100, 10'd0, 5'b11100}) holdBad = i + 1;
    end
    checks++;
    if (holdBad != 0) begin failures++; $display("FAIL pause_hold: first bad paused clk %0d, want none", holdBad); end
    iEn = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge iClk);
      expX   = (j <= 3) ? 100 : 101;
      expPix = (j == 3) || (j == 7);
      checks++;
      if (int'(aX) != expX || aPixTick !== expPix) begin
        failures++;
        $display("FAIL pause_resume clk %0d: x=%0d pix=%b, want %0d %b", j, aX, aPixTick, expX, expPix);
      end
    end
    iEn = 1'b0;
    @(negedge iClk);
    checks++;
    if ({aX, aPixTick} !== {10'd101, 1'b0}) begin
      failures++;
      $display("FAIL pause_kills_pulse: x=%0d pix=%b, want 101 0", aX, aPixTick);
    end
    iEn = 1'b1;
    @(negedge iClk);
    checks++;
    if ({aX, aPixTick} !== {10'd102, 1'b0}) begin
      failures++;
      $display("FAIL pause_second_resume: x=%0d pix=%b, want 102 0", aX, aPixTick);
    end
  endtask

  task automatic test_reset_midframe();
    doReset();
    repeat (9201) @(negedge iClk);
    checks++;
    if ({aX, aY, aHSync, aVideoOn} !== {10'd700, 10'd2, 2'b00}) begin
      failures++;
      $display("FAIL midframe_pos: x=%0d y=%0d hs=%b vid=%b, want 700 2 0 0", aX, aY, aHSync, aVideoOn);
    end
    iRst = 1'b1;
    iEn  = 1'b0;
    @(negedge iClk);
    checks++;
    if ({aX, aY, aHSync, aVSync, aVideoOn, aPixTick, aFrameStart} !== {20'd0, 5'b11000}) begin
      failures++;
      $display("FAIL midframe_reset: x=%0d y=%0d hs=%b vs=%b vid=%b pix=%b fs=%b, want 0 0 1 1 0 0 0",
               aX, aY, aHSync, aVSync, aVideoOn, aPixTick, aFrameStart);
    end
    iRst = 1'b0;
    iEn  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge iClk);
      checks++;
      if ({aX, aY, aVideoOn, aPixTick, aFrameStart} !==
          {10'((k - 1) / 4), 10'd0, 1'b1, (k == 4), (k == 4)}) begin
        failures++;
        $display("FAIL midframe_restart edge %0d: x=%0d y=%0d vid=%b pix=%b fs=%b, want %0d 0 1 %b %b",
                 k, aX, aY, aVideoOn, aPixTick, aFrameStart, (k - 1) / 4, (k == 4), (k == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_min_params();
    test_enable_pause();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
